// File: rtl/myhardware_stream_mem_writer_if.sv
// Stream sink plus Avalon-MM write bus of myhardware_stream_mem_writer.
// master: the writer's view; slave: the upstream source / RAM side.
interface myhardware_stream_mem_writer_if #(
  parameter int ADDR_W = 13
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata, mem_clken
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata, mem_clken
  );
endinterface

// File: rtl/myhardware_stream_mem_writer.sv
// Stream-to-RAM writer: each accepted beat is written one cycle later.
// Define STREAM_WRITER_CHECKSUM_EN to build the running job checksum.
module myhardware_stream_mem_writer #(
  parameter int DEPTH  = 5000,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  myhardware_stream_mem_writer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam logic [ADDR_W+1:0] LIMIT =
    (ADDR_W+2)'(DEPTH);

  state_t state_q, state_d;

  logic [ADDR_W:0]   base_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   ww_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       data_q;
  logic [ADDR_W+1:0] span;
  logic              wr_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              launch;
  logic              accept;
  logic              last;

  // Wide enough that base+count can never wrap
  assign span    = {2'b00, base} + {1'b0, count};
  assign addr_nx = ADDR_W'(base_q + idx_q);
  assign accept  = (state_q == RUN) && bus.in_valid;
  assign last    = accept && (idx_q == cnt_q - 1'b1);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else if (span > LIMIT) begin
            err_d = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // A final beat wins over a same-cycle abort
        if (last) begin
          state_d = FLUSH;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = FLUSH;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ww_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= accept;
      if (launch) begin
        base_q <= {1'b0, base};
        cnt_q  <= count;
        idx_q  <= '0;
        ww_q   <= '0;
      end
      if (accept) begin
        idx_q  <= idx_q + 1'b1;
        ww_q   <= ww_q + 1'b1;
        addr_q <= addr_nx;
        data_q <= bus.in_data;
      end
    end
  end

`ifdef STREAM_WRITER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (launch) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + bus.in_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign bus.in_ready       = (state_q == RUN);
  assign bus.mem_write      = wr_q;
  assign bus.mem_chipselect = wr_q;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_address    = addr_q;
  assign bus.mem_writedata  = data_q;
  assign bus.mem_clken      = reset_n;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign err                = err_q;
  assign words_written      = ww_q;

endmodule

// File: tb/tb_myhardware_stream_mem_writer.sv
// Directed bench for myhardware_stream_mem_writer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_myhardware_stream_mem_writer;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 5000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;
  logic [31:0]       checksum;

  int vectors    = 0;
  int miscompares = 0;
  int wr_cnt     = 0;

  myhardware_stream_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

  myhardware_stream_mem_writer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base         (base),
    .count        (count),
    .abort        (abort),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_write) wr_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int b, input int c);
    start = 1'b1;
    base  = ADDR_W'(b);
    count = (ADDR_W+1)'(c);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(bus.mem_write), 32'd1);
    chk({tag, "_cs"}, 32'(bus.mem_chipselect), 32'd1);
    chk({tag, "_ad"}, 32'(bus.mem_address), 32'(a));
    chk({tag, "_da"}, bus.mem_writedata, d);
  endtask

  logic [31:0] exp_sum;
  logic [4:0]  pat;
  int          nacc;

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    base         = '0;
    count        = '0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdy", 32'(bus.in_ready), 0);
    chk("rst_we", 32'(bus.mem_write), 0);
    chk("rst_cs", 32'(bus.mem_chipselect), 0);
    chk("rst_ad", 32'(bus.mem_address), 0);
    chk("rst_da", bus.mem_writedata, 0);
    chk("rst_ww", 32'(words_written), 0);
    chk("rst_ck", checksum, 0);
    chk("rst_be", 32'(bus.mem_byteenable), 32'hF);
    chk("rst_clk", 32'(bus.mem_clken), 0);
    reset_n = 1'b1;
    tick();
    chk("clken", 32'(bus.mem_clken), 1);

    // Continuous four-beat job
    go(0, 4);
    chk("j1_busy", 32'(busy), 1);
    chk("j1_rdy", 32'(bus.in_ready), 1);
    chk("j1_ww0", 32'(words_written), 0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11 * (i + 1);
      tick();
      chk_wr("j1", i, 32'h11 * (i + 1));
      chk("j1_ww", 32'(words_written), 32'(i + 1));
      chk("j1_done", 32'(done), (i == 3) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    chk("j1_flush_rdy", 32'(bus.in_ready), 0);
    chk("j1_flush_busy", 32'(busy), 1);
    tick();
    chk("j1_idle_we", 32'(bus.mem_write), 0);
    chk("j1_idle_busy", 32'(busy), 0);
    chk("j1_done_1cy", 32'(done), 0);
    chk("j1_ww_hold", 32'(words_written), 4);
    chk("j1_ad_hold", 32'(bus.mem_address), 3);
    chk("j1_da_hold", bus.mem_writedata, 32'h44);
`ifdef STREAM_WRITER_CHECKSUM_EN
    exp_sum = 32'hAA;
`else
    exp_sum = 32'h0;
`endif
    chk("j1_ck", checksum, exp_sum);

    // Gapped stream
    go(100, 3);
    pat  = 5'b10101;
    nacc = 0;
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = pat[j];
      bus.in_data  = 32'h100 + 32'(j);
      tick();
      chk("j2_we", 32'(bus.mem_write), 32'(pat[j]));
      chk("j2_ad", 32'(bus.mem_address), 32'(100 + nacc - (pat[j] ? 0 : 1)));
      if (pat[j]) begin
        chk("j2_da", bus.mem_writedata, 32'h100 + 32'(j));
        nacc++;
      end
      chk("j2_done", 32'(done), (j == 4) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("j2_ww", 32'(words_written), 3);

    // Out of range then exactly at the top of memory
    go(4990, 11);
    chk("j3_err", 32'(err), 1);
    chk("j3_busy", 32'(busy), 0);
    chk("j3_rdy", 32'(bus.in_ready), 0);
    chk("j3_done", 32'(done), 0);
    tick();
    chk("j3_err_1cy", 32'(err), 0);
    go(4990, 10);
    chk("j3b_busy", 32'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA000 + 32'(i);
      tick();
      chk_wr("j3b", 4990 + i, 32'hA000 + 32'(i));
    end
    bus.in_valid = 1'b0;
    chk("j3b_done", 32'(done), 1);
    chk("j3b_err", 32'(err), 0);
    tick();

    // Zero-length job, then start while busy
    go(7, 0);
    chk("j4_done", 32'(done), 1);
    chk("j4_busy", 32'(busy), 0);
    chk("j4_we", 32'(bus.mem_write), 0);
    go(200, 2);
    beat(32'hBEEF0000);
    chk_wr("j4a", 200, 32'hBEEF0000);
    start = 1'b1;
    base  = ADDR_W'(300);
    count = (ADDR_W+1)'(5);
    beat(32'hBEEF0001);
    start = 1'b0;
    chk_wr("j4b", 201, 32'hBEEF0001);
    chk("j4b_done", 32'(done), 1);
    tick();
    chk("j4_ign_busy", 32'(busy), 0);

    // Abort after three accepts
    go(0, 8);
    for (int i = 0; i < 3; i++) begin
      beat(32'hC0 + 32'(i));
      chk_wr("j5", i, 32'hC0 + 32'(i));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("j5_done", 32'(done), 1);
    chk("j5_err", 32'(err), 1);
    chk("j5_we", 32'(bus.mem_write), 0);
    chk("j5_ww", 32'(words_written), 3);
    tick();
    chk("j5_busy", 32'(busy), 0);
    chk("j5_err_1cy", 32'(err), 0);

    // Abort alongside the final beat completes normally
    go(50, 2);
    beat(32'hD0);
    abort = 1'b1;
    beat(32'hD1);
    abort = 1'b0;
    chk_wr("j6", 51, 32'hD1);
    chk("j6_done", 32'(done), 1);
    chk("j6_err", 32'(err), 0);
    tick();

    // Reset while a beat is being accepted
    go(10, 5);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD;
    reset_n      = 1'b0;
    tick();
    chk("j7_we", 32'(bus.mem_write), 0);
    chk("j7_cs", 32'(bus.mem_chipselect), 0);
    chk("j7_busy", 32'(busy), 0);
    chk("j7_rdy", 32'(bus.in_ready), 0);
    chk("j7_ad", 32'(bus.mem_address), 0);
    chk("j7_ww", 32'(words_written), 0);
    chk("j7_clk", 32'(bus.mem_clken), 0);
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    tick();
    chk("j7_idle", 32'(busy), 0);
    go(20, 2);
    beat(32'hE0);
    chk_wr("j7a", 20, 32'hE0);
    beat(32'hE1);
    chk_wr("j7b", 21, 32'hE1);
    chk("j7_done", 32'(done), 1);
    tick();
    chk("j7_ww2", 32'(words_written), 2);
    tick();

    chk("total_writes", 32'(wr_cnt), 26);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/myhardware_stream_mem_writer.md
MYHARDWARE_STREAM_MEM_WRITER -- requirements
Module: myhardware_stream_mem_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 5000, memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports start  input  1, base  input  ADDR_W, count  input  ADDR_W+1: job start pulse, first word address, word count.
REQ-006 SHALL have port abort  input  1  terminates the running job.
REQ-007 SHALL have ports in_valid  input  1, in_data  input  32, in_ready  output  1: upstream stream beat handshake.
REQ-008 SHALL have ports mem_address  output  ADDR_W, mem_byteenable  output  4, mem_chipselect  output  1, mem_write  output  1, mem_writedata  output  32, mem_clken  output  1: zero-wait-state Avalon-MM write master toward on-chip RAM.
REQ-009 SHALL have ports busy  output  1, done  output  1, err  output  1, words_written  output  ADDR_W+1, checksum  output  32.

Function
REQ-010 SHALL implement states IDLE, RUN, FLUSH.
REQ-011 IDLE + start: if count==0 -> done pulses next cycle, no writes, stay IDLE; if base+count > DEPTH -> err pulses next cycle, job rejected, stay IDLE; else latch base/count, clear words_written, -> RUN.
REQ-012 start SHALL be ignored outside IDLE.
REQ-013 in_ready SHALL be 1 exactly when state==RUN; a beat is accepted when in_valid && in_ready.
REQ-014 Accepted beat k (0-based) in cycle N SHALL produce in cycle N+1: mem_write=1, mem_chipselect=1, mem_byteenable=4'hF, mem_address=base+k, mem_writedata=in_data.
REQ-015 mem_write and mem_chipselect SHALL be 0 in every cycle without a pending beat; at most one write per cycle; back-to-back beats give back-to-back writes.
REQ-016 mem_clken SHALL be 1 whenever reset_n is 1.
REQ-017 words_written SHALL increment by 1 in the cycle each write is presented.
REQ-018 Accepting beat count-1 SHALL move RUN -> FLUSH; FLUSH presents the final write and -> IDLE; done SHALL pulse 1 cycle in that final-write cycle.
REQ-019 busy SHALL be 1 in RUN and FLUSH, 0 in IDLE.
REQ-020 abort in RUN SHALL deassert in_ready next cycle, -> FLUSH; any beat accepted in the abort cycle is still written; done and err both pulse in the FLUSH cycle.
REQ-021 abort together with accepting the final beat SHALL be treated as normal completion (done only, no err).
REQ-022 Address arithmetic SHALL be ADDR_W+1 bits wide; mem_address never exceeds DEPTH-1 and never wraps.
REQ-023 When mem_write is 0, mem_address/mem_writedata SHALL hold last values.

Reset
REQ-024 reset_n low at a clock edge SHALL force IDLE; busy, done, err, in_ready, mem_write, mem_chipselect=0; mem_address, mem_writedata, words_written, checksum=0; mem_byteenable=4'hF.
REQ-025 reset mid-job SHALL drop any pending write (no mem_write the next cycle) and discard the job.
REQ-026 mem_clken SHALL be 0 while reset_n is low.

Configuration
REQ-027 Macro STREAM_WRITER_CHECKSUM_EN defined: checksum is the modulo-2^32 sum of mem_writedata over all writes of the current job, updated in each write cycle, cleared on accepted start, held after done.
REQ-028 Macro STREAM_WRITER_CHECKSUM_EN undefined: checksum is constant 0 and no adder is synthesized.

Verification
REQ-029 base=0, count=4, beats 0x11,0x22,0x33,0x44 continuous -> writes at addr 0..3 on 4 consecutive cycles, done in 4th write cycle, words_written=4, checksum=0xAA (macro on).
REQ-030 base=100, count=3, in_valid toggling 1,0,1,0,1 -> writes only at addr 100,101,102, one cycle after each accept, mem_write 0 in gaps.
REQ-031 base=4990, count=11 -> err pulse next cycle, busy stays 0, no mem_write; base=4990, count=10 -> last write at addr 4999.
REQ-032 count=0 -> done next cycle, no mem_write; start while busy -> ignored, current job addresses unchanged.
REQ-033 base=0, count=8, abort after 3 accepts -> exactly 3 writes (addr 0..2), done+err pulse together, words_written=3.
REQ-034 reset_n low 1 cycle during RUN with beat just accepted -> no write next cycle, all outputs per REQ-024, new job then runs normally.
